branch_predictor: RTL and testbench

Next-PC generator sitting directly upstream of the PC register: it takes the current fetch PC, looks it up in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and drives the next fetch address into the PC register's `pc_i`. Branch outcomes resolved in EX update the table, and mispredict redirects override the prediction in the same cycle.

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: next-PC generator with a direct-mapped BTB and 2-bit
// saturating direction counters. The lookup is combinational on the fetch PC.
// Branches resolved in EX train the table at the clock edge, and an EX redirect
// overrides the prediction in the same cycle.
// Optional feature macro: BP_STATS_EN adds free-running lookup/redirect counters.
`timescale 1ns/1ps

module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  output logic [31:0] next_pc_o,
  output logic        pred_taken_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_lookups_o,
  output logic [31:0] stat_redirects_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // Saturating counter helpers.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // The table is built from flops so that reset can clear every entry in one
  // edge. Only valid/ctr are reset; tag/target are qualified by valid.
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  // Lookup side.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  // Update side.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = fetch_pc_i[IDX_W+1:2];
  assign lk_tag = fetch_pc_i[31:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];

  // Byte-offset bits of both PCs are deliberately ignored.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // Combinational BTB probe for the fetch PC and for the training PC.
  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][1];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Next-PC select: reset, then redirect, then predicted target, then PC+4.
  always_comb begin
    next_pc_o    = fetch_pc_i + 32'd4;
    pred_taken_o = 1'b0;
    if (rst_i) begin
      next_pc_o = 32'h0;
    end else if (redirect_i) begin
      next_pc_o = redirect_pc_i;
    end else if (lk_taken) begin
      next_pc_o    = target_q[lk_idx];
      pred_taken_o = 1'b1;
    end
  end

  // Control state: entry valid bits and direction counters. Reset wins over
  // a concurrent update, which is simply dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ctr_q   <= '{default: CTR_WEAK_NT};
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= upd_taken_i ? sat_inc(ctr_q[up_idx]) : sat_dec(ctr_q[up_idx]);
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // Data state: tag/target are written on every taken update. On a hit the tag
  // is unchanged by construction; on a miss this is the allocation.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

`ifdef BP_STATS_EN
  // Statistics counters; both wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_lookups_o   <= 32'h0;
      stat_redirects_o <= 32'h0;
    end else begin
      if (!stall_i) begin
        stat_lookups_o <= stat_lookups_o + 32'd1;
      end
      if (redirect_i) begin
        stat_redirects_o <= stat_redirects_o + 32'd1;
      end
    end
  end
`else
  // stall_i only gates the statistics counters.
  logic unused_stall;
  assign unused_stall = stall_i;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor (ENTRIES=16).
// The driver pushes the expected {next_pc, pred_taken} for every driven cycle,
// and the monitor pops and compares on the falling edge.
`timescale 1ns/1ps

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] next_pc;
  logic        pred_taken;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_redirects;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_pc_i    (fetch_pc),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .next_pc_o     (next_pc),
    .pred_taken_o  (pred_taken)
`ifdef BP_STATS_EN
    ,
    .stat_lookups_o   (stat_lookups),
    .stat_redirects_o (stat_redirects)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One driven cycle: apply inputs just after the rising edge and record the
  // expected combinational outputs for that cycle.
  task automatic cyc(input logic r, input logic [31:0] f, input logic st,
                     input logic rd, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt,
                     input logic [31:0] e_pc, input logic e_tk, input string tag);
    @(posedge clk);
    #1;
    rst         = r;
    fetch_pc    = f;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    exp_q.push_back({e_pc, e_tk});
    tag_q.push_back(tag);
  endtask

  // Monitor: compare one scoreboard entry per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [32:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {31'd0, next_pc, pred_taken}, {31'd0, e});
    end
  end

  initial begin
    rst = 1'b1; fetch_pc = 32'h100; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0;

    //  rst fetch          st rd rpc        uv upc       ut tgt         exp_pc        tk
    cyc(1, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h0,        0, "rst_cyc0");
    cyc(1, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h200,    32'h0,        0, "rst_cyc1_upd");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h104,      0, "cold_rst_drops_upd");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h200,    32'h104,      0, "alloc_same_cycle");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h200,      1, "alloc_hit");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  0, 32'h0,      32'h200,      1, "nt_same_cycle");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h104,      0, "weak_nt");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h200,    32'h104,      0, "inc1_old");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h200,    32'h200,      1, "inc2_weak_t");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  0, 32'h0,      32'h200,      1, "dec_from_strong");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h200,      1, "hyst_hold");
    cyc(0, 32'h140,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h144,      0, "alias_miss");
    cyc(0, 32'h140,        0, 0, 32'h0,     1, 32'h140,  1, 32'h300,    32'h144,      0, "alias_alloc_old");
    cyc(0, 32'h140,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h300,      1, "alias_hit");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h104,      0, "alias_evicted");
    cyc(0, 32'h104,        0, 0, 32'h0,     1, 32'h100,  1, 32'h200,    32'h108,      0, "realloc_other_idx");
    cyc(0, 32'h100,        1, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h200,      1, "stall_no_effect");
    cyc(0, 32'h100,        0, 1, 32'h80,    1, 32'h100,  0, 32'h0,      32'h80,       0, "redirect_over_hit");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h104,      0, "redirect_upd_applied");
    cyc(0, 32'hFFFFFFFC,   0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h0,        0, "pc_wrap");
    cyc(0, 32'h200,        0, 1, 32'h1234,  0, 32'h0,    0, 32'h0,      32'h1234,     0, "redirect_miss");
    cyc(0, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h400,    32'h104,      0, "tgt_upd_old");
    cyc(0, 32'h103,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h400,      1, "tgt_upd_lsb_ignored");
    cyc(1, 32'h100,        0, 0, 32'h0,     1, 32'h100,  1, 32'h500,    32'h0,        0, "mid_reset");
    cyc(0, 32'h100,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h104,      0, "training_discarded");
    cyc(0, 32'h140,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h144,      0, "alias_discarded");

`ifdef BP_STATS_EN
    cyc(1, 32'h200,        1, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h0,        0, "stats_rst");
    cyc(0, 32'h200,        1, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h204,      0, "stats_idle");
    check("stat_lookups_rst", {32'd0, stat_lookups}, 64'd0);
    check("stat_redirects_rst", {32'd0, stat_redirects}, 64'd0);
    cyc(0, 32'h200,        0, 1, 32'h40,    0, 32'h0,    0, 32'h0,      32'h40,       0, "stats_p0");
    cyc(0, 32'h200,        1, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h204,      0, "stats_p1");
    cyc(0, 32'h200,        0, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h204,      0, "stats_p2");
    cyc(0, 32'h200,        1, 1, 32'h44,    0, 32'h0,    0, 32'h0,      32'h44,       0, "stats_p3");
    cyc(0, 32'h200,        1, 0, 32'h0,     0, 32'h0,    0, 32'h0,      32'h204,      0, "stats_p4");
    check("stat_lookups_count", {32'd0, stat_lookups}, 64'd2);
    check("stat_redirects_count", {32'd0, stat_redirects}, 64'd2);
`endif

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
